// File: rtl/jpeg_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : jpeg_arb_pkg
//  Description : Shared definitions for the two-requester JPEG stream
//                arbiter: FSM state encoding and counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package jpeg_arb_pkg;

    // Width of the per-requester frame counters and the drain cycle counter.
    localparam int c_cnt_w = 16;

    // IDLE   : no grant, waiting for a requester
    // STREAM : granted requester is forwarded to the decoder
    // DRAIN  : frame delivered, waiting for the decoder to finish it
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DRAIN  = 2'd2
    } arb_state_t;

endpackage : jpeg_arb_pkg
`default_nettype wire

// File: rtl/jpeg_arb_rr.sv
`default_nettype none
// ============================================================================
//  Module      : jpeg_arb_rr
//  Description : Two-way round-robin picker (purely combinational).
//                The requester selected by i_prio wins a tie; otherwise the
//                single active requester is granted.
//  Ports       : i_req0 / i_req1 - request lines
//                i_prio          - requester holding priority (0 or 1)
//                o_grant         - one-hot grant, 2'b00 when nobody asks
//  Revision    : 1.0 - initial release
// ============================================================================
module jpeg_arb_rr
    import jpeg_arb_pkg::*;
(
    input  logic       i_req0,
    input  logic       i_req1,
    input  logic       i_prio,
    output logic [1:0] o_grant
);

    always_comb begin
        o_grant = 2'b00;
        if (i_prio) begin
            if (i_req1) begin
                o_grant = 2'b10;
            end else if (i_req0) begin
                o_grant = 2'b01;
            end
        end else begin
            if (i_req0) begin
                o_grant = 2'b01;
            end else if (i_req1) begin
                o_grant = 2'b10;
            end
        end
    end

endmodule : jpeg_arb_rr
`default_nettype wire

// File: rtl/jpeg_stream_arb.sv
`default_nettype none
// ============================================================================
//  Module      : jpeg_stream_arb
//  Description : Frame-level arbiter placing one of two JPEG word streams
//                onto a single decoder input. A grant is held for a whole
//                frame (no preemption); between frames the block can wait
//                for the decoder to drain, bounded by a timeout.
//  Ports       : clk_i, rst_i                  - clock, sync active-high reset
//                in{0,1}_valid/data/strb/last  - requester streams
//                in{0,1}_accept_o              - per-requester accept
//                outport_*                     - stream to decoder input
//                decoder_idle_i                - decoder pixel side idle
//                owner_o                       - requester owning the decoder
//                busy_o                        - not in IDLE
//                timeout_o                     - sticky drain timeout flag
//                frame_cnt{0,1}_o              - completed frames
//  Revision    : 1.0 - initial release
// ============================================================================
module jpeg_stream_arb
    import jpeg_arb_pkg::*;
#(
    parameter int DRAIN_TIMEOUT = 65535,
    parameter int WAIT_IDLE     = 1
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        in0_valid_i,
    input  logic [31:0] in0_data_i,
    input  logic [3:0]  in0_strb_i,
    input  logic        in0_last_i,
    output logic        in0_accept_o,
    input  logic        in1_valid_i,
    input  logic [31:0] in1_data_i,
    input  logic [3:0]  in1_strb_i,
    input  logic        in1_last_i,
    output logic        in1_accept_o,
    output logic        outport_valid_o,
    output logic [31:0] outport_data_o,
    output logic [3:0]  outport_strb_o,
    output logic        outport_last_o,
    input  logic        outport_accept_i,
    input  logic        decoder_idle_i,
    output logic        owner_o,
    output logic        busy_o,
    output logic        timeout_o,
    output logic [15:0] frame_cnt0_o,
    output logic [15:0] frame_cnt1_o
);

    // Drain counter value on the last permitted DRAIN cycle.
    localparam logic [c_cnt_w-1:0] c_drain_last = c_cnt_w'(DRAIN_TIMEOUT - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one    = c_cnt_w'(1);

    arb_state_t           r_state;
    arb_state_t           w_state_nxt;
    logic [1:0]           r_grant;
    logic [1:0]           w_grant_nxt;
    logic                 r_owner;
    logic                 w_owner_nxt;
    logic                 r_prio;
    logic                 w_prio_nxt;
    logic                 r_timeout;
    logic                 w_timeout_nxt;
    logic                 r_busy_seen;
    logic                 w_busy_seen_nxt;
    logic [c_cnt_w-1:0]   r_cnt0;
    logic [c_cnt_w-1:0]   w_cnt0_nxt;
    logic [c_cnt_w-1:0]   r_cnt1;
    logic [c_cnt_w-1:0]   w_cnt1_nxt;
    logic [c_cnt_w-1:0]   r_drain_cnt;
    logic [c_cnt_w-1:0]   w_drain_cnt_nxt;
    logic [1:0]           w_rr_grant;
    logic                 w_xfer;

    jpeg_arb_rr u_rr (
        .i_req0  (in0_valid_i),
        .i_req1  (in1_valid_i),
        .i_prio  (r_prio),
        .o_grant (w_rr_grant)
    );

    // ------------------------------------------------------------------
    // Stream mux. The grant is only non-zero in STREAM, so it alone gates
    // the datapath; outside a frame everything towards the decoder is 0.
    // ------------------------------------------------------------------
    always_comb begin
        outport_valid_o = (r_grant[0] & in0_valid_i) | (r_grant[1] & in1_valid_i);
        outport_last_o  = (r_grant[0] & in0_last_i)  | (r_grant[1] & in1_last_i);
        outport_data_o  = '0;
        outport_strb_o  = '0;
        if (r_grant[1]) begin
            outport_data_o = in1_data_i;
            outport_strb_o = in1_strb_i;
        end else if (r_grant[0]) begin
            outport_data_o = in0_data_i;
            outport_strb_o = in0_strb_i;
        end
        in0_accept_o = r_grant[0] & outport_accept_i;
        in1_accept_o = r_grant[1] & outport_accept_i;
    end

    assign w_xfer       = outport_valid_o & outport_accept_i & outport_last_o;
    assign owner_o      = r_owner;
    assign busy_o       = (r_state != IDLE);
    assign timeout_o    = r_timeout;
    assign frame_cnt0_o = r_cnt0;
    assign frame_cnt1_o = r_cnt1;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt     = r_state;
        w_grant_nxt     = r_grant;
        w_owner_nxt     = r_owner;
        w_prio_nxt      = r_prio;
        w_timeout_nxt   = r_timeout;
        w_busy_seen_nxt = r_busy_seen;
        w_cnt0_nxt      = r_cnt0;
        w_cnt1_nxt      = r_cnt1;
        w_drain_cnt_nxt = r_drain_cnt;

        case (r_state)
            IDLE: begin
                if (|w_rr_grant) begin
                    w_grant_nxt = w_rr_grant;
                    w_owner_nxt = w_rr_grant[1];
                    w_state_nxt = STREAM;
                end
            end

            STREAM: begin
                if (w_xfer) begin
                    if (r_grant[1]) begin
                        w_cnt1_nxt = r_cnt1 + c_cnt_one;
                    end else begin
                        w_cnt0_nxt = r_cnt0 + c_cnt_one;
                    end
                    // The requester just served loses priority.
                    w_prio_nxt      = ~r_grant[1];
                    w_grant_nxt     = 2'b00;
                    w_drain_cnt_nxt = '0;
                    w_busy_seen_nxt = 1'b0;
                    w_state_nxt     = (WAIT_IDLE != 0) ? DRAIN : IDLE;
                end
            end

            DRAIN: begin
                w_drain_cnt_nxt = r_drain_cnt + c_cnt_one;
                // A drain only completes once the decoder has been seen
                // busy with the frame and has then gone idle again; idle
                // before that is the previous frame's leftover state.
                if (!decoder_idle_i) begin
                    w_busy_seen_nxt = 1'b1;
                end
                if (r_drain_cnt == c_drain_last) begin
                    w_state_nxt   = IDLE;
                    w_timeout_nxt = 1'b1;
                end else if (r_busy_seen && decoder_idle_i) begin
                    w_state_nxt = IDLE;
                end
            end

            default: begin
                w_state_nxt = IDLE;
                w_grant_nxt = 2'b00;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state     <= IDLE;
            r_grant     <= 2'b00;
            r_owner     <= 1'b0;
            r_prio      <= 1'b0;
            r_timeout   <= 1'b0;
            r_busy_seen <= 1'b0;
            r_cnt0      <= '0;
            r_cnt1      <= '0;
            r_drain_cnt <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_grant     <= w_grant_nxt;
            r_owner     <= w_owner_nxt;
            r_prio      <= w_prio_nxt;
            r_timeout   <= w_timeout_nxt;
            r_busy_seen <= w_busy_seen_nxt;
            r_cnt0      <= w_cnt0_nxt;
            r_cnt1      <= w_cnt1_nxt;
            r_drain_cnt <= w_drain_cnt_nxt;
        end
    end

endmodule : jpeg_stream_arb
`default_nettype wire

// File: tb/tb_jpeg_stream_arb.sv
`default_nettype none
// ============================================================================
//  Module      : tb_jpeg_stream_arb
//  Description : Self-checking bench for jpeg_stream_arb. Three instances
//                share one stimulus: [0] defaults, [1] DRAIN_TIMEOUT=8,
//                [2] WAIT_IDLE=0. A behavioural model predicts every
//                output each cycle; directed scenarios add literal checks.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_jpeg_stream_arb;

    localparam int P_IDLE   = 0;
    localparam int P_STREAM = 1;
    localparam int P_DRAIN  = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic        in0_valid, in1_valid;
    logic [31:0] in0_data, in1_data;
    logic [3:0]  in0_strb, in1_strb;
    logic        in0_last, in1_last;
    logic        oacc, didle;

    logic [2:0]  a0, a1, ov, ol, own, bsy, tmo;
    logic [31:0] od  [3];
    logic [3:0]  os  [3];
    logic [15:0] fc0 [3];
    logic [15:0] fc1 [3];

    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
        jpeg_stream_arb #(
            .DRAIN_TIMEOUT (gi == 1 ? 8 : 65535),
            .WAIT_IDLE     (gi == 2 ? 0 : 1)
        ) u_dut (
            .clk_i            (clk),
            .rst_i            (rst),
            .in0_valid_i      (in0_valid),
            .in0_data_i       (in0_data),
            .in0_strb_i       (in0_strb),
            .in0_last_i       (in0_last),
            .in0_accept_o     (a0[gi]),
            .in1_valid_i      (in1_valid),
            .in1_data_i       (in1_data),
            .in1_strb_i       (in1_strb),
            .in1_last_i       (in1_last),
            .in1_accept_o     (a1[gi]),
            .outport_valid_o  (ov[gi]),
            .outport_data_o   (od[gi]),
            .outport_strb_o   (os[gi]),
            .outport_last_o   (ol[gi]),
            .outport_accept_i (oacc),
            .decoder_idle_i   (didle),
            .owner_o          (own[gi]),
            .busy_o           (bsy[gi]),
            .timeout_o        (tmo[gi]),
            .frame_cnt0_o     (fc0[gi]),
            .frame_cnt1_o     (fc1[gi])
        );
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s[%0d]: got %0h, expected %0h (t=%0t)", nm, idx, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Behavioural model: per instance, which phase, who owns the decoder,
    // who has priority, how long we have been draining, frames done.
    // ------------------------------------------------------------------
    int m_ph   [3];
    int m_gnt  [3];
    int m_own  [3];
    int m_pri  [3];
    int m_tmo  [3];
    int m_dcnt [3];
    int m_seen [3];
    int m_cnt  [3][2];
    bit m_live = 1'b0;

    function automatic int m_timeout(input int i);
        return (i == 1) ? 8 : 65535;
    endfunction

    // Compare outputs against the model, then advance it by one clock.
    // Called at the falling edge; inputs are stable until the next rise.
    task automatic model_cycle();
        for (int i = 0; i < 3; i++) begin
            int g;
            bit strm;
            bit ev, el;
            logic [31:0] ed;
            logic [3:0]  es;
            g    = m_gnt[i];
            strm = (m_ph[i] == P_STREAM);
            ev   = strm && ((g == 0) ? in0_valid : in1_valid);
            el   = (g == 0) ? in0_last : in1_last;
            ed   = (g == 0) ? in0_data : in1_data;
            es   = (g == 0) ? in0_strb : in1_strb;
            if (m_live) begin
                chk("out_valid", i, 32'(ov[i]),  32'(ev));
                chk("acc0",      i, 32'(a0[i]),  32'(strm && g == 0 && oacc));
                chk("acc1",      i, 32'(a1[i]),  32'(strm && g == 1 && oacc));
                chk("owner",     i, 32'(own[i]), 32'(m_own[i]));
                chk("busy",      i, 32'(bsy[i]), 32'(m_ph[i] != P_IDLE));
                chk("timeout",   i, 32'(tmo[i]), 32'(m_tmo[i]));
                chk("fcnt0",     i, 32'(fc0[i]), 32'(m_cnt[i][0]));
                chk("fcnt1",     i, 32'(fc1[i]), 32'(m_cnt[i][1]));
                if (ev) begin
                    chk("out_data", i, od[i],        ed);
                    chk("out_strb", i, 32'(os[i]),   32'(es));
                    chk("out_last", i, 32'(ol[i]),   32'(el));
                end
            end
            if (rst) begin
                m_ph[i] = P_IDLE; m_gnt[i] = -1; m_own[i] = 0; m_pri[i] = 0;
                m_tmo[i] = 0; m_dcnt[i] = 0; m_seen[i] = 0;
                m_cnt[i][0] = 0; m_cnt[i][1] = 0;
            end else if (m_ph[i] == P_IDLE) begin
                if (in0_valid || in1_valid) begin
                    int w;
                    if (m_pri[i] == 0) w = in0_valid ? 0 : 1;
                    else               w = in1_valid ? 1 : 0;
                    m_gnt[i] = w; m_own[i] = w; m_ph[i] = P_STREAM;
                end
            end else if (m_ph[i] == P_STREAM) begin
                if (ev && oacc && el) begin
                    m_cnt[i][g] = (m_cnt[i][g] + 1) % 65536;
                    m_pri[i] = 1 - g;
                    m_gnt[i] = -1;
                    m_dcnt[i] = 0; m_seen[i] = 0;
                    m_ph[i] = (i == 2) ? P_IDLE : P_DRAIN;
                end
            end else begin
                m_dcnt[i]++;
                if (m_dcnt[i] == m_timeout(i)) begin
                    m_ph[i] = P_IDLE; m_tmo[i] = 1;
                end else if (m_seen[i] != 0 && didle) begin
                    m_ph[i] = P_IDLE;
                end
                if (!didle) m_seen[i] = 1;
            end
        end
        if (rst) m_live = 1'b1;
    endtask

    task automatic tick();
        @(negedge clk);
        model_cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int k;
        int nacc;
        bit acc;

        rst = 1'b1; in0_valid = 0; in1_valid = 0;
        in0_data = '0; in1_data = '0; in0_strb = '0; in1_strb = '0;
        in0_last = 0; in1_last = 0; oacc = 1'b1; didle = 1'b1;
        tick(); tick();

        // Reset state
        for (int i = 0; i < 3; i++) begin
            chk("rst_busy",  i, 32'(bsy[i]), 0);
            chk("rst_owner", i, 32'(own[i]), 0);
            chk("rst_tmo",   i, 32'(tmo[i]), 0);
            chk("rst_fc0",   i, 32'(fc0[i]), 0);
        end
        rst = 1'b0;

        // Both requesters at once after reset: requester 0 wins
        in0_valid = 1; in1_valid = 1;
        in0_data = 32'hA000_0000; in0_strb = 4'hF;
        in1_data = 32'hB000_0000; in1_strb = 4'h3;
        tick();
        chk("a_owner", 0, 32'(own[0]), 0);
        chk("a_busy",  0, 32'(bsy[0]), 1);
        for (int w = 0; w < 3; w++) begin
            in0_data = 32'hA000_0000 + 32'(w);
            in0_last = (w == 2);
            #1;
            chk("a_in1_acc", 0, 32'(a1[0]), 0);
            chk("a_in0_acc", 0, 32'(a0[0]), 1);
            tick();
        end
        chk("a_fc0",     0, 32'(fc0[0]), 1);
        chk("a_drain",   0, 32'(bsy[0]), 1);
        chk("a_nw_idle", 2, 32'(bsy[2]), 0);
        chk("a_nw_fc0",  2, 32'(fc0[2]), 1);

        // Drain handshake: idle 10 cycles, busy 20, then idle again
        in0_valid = 0; in0_last = 0; in1_last = 0;
        for (int j = 0; j <= 30; j++) begin
            didle = (j < 10 || j >= 30);
            tick();
            if (j == 7) begin
                chk("to_exit_busy", 1, 32'(bsy[1]), 0);
                chk("to_flag",      1, 32'(tmo[1]), 1);
            end
            if (j == 29) chk("d_still_drain", 0, 32'(bsy[0]), 1);
            if (j == 30) begin
                chk("d_idle",       0, 32'(bsy[0]), 0);
                chk("d_owner_hold", 0, 32'(own[0]), 0);
            end
        end
        tick();
        chk("d_next_owner", 0, 32'(own[0]), 1);
        chk("d_next_busy",  0, 32'(bsy[0]), 1);
        chk("d_next_acc0",  0, 32'(a0[0]), 0);
        chk("d_to_sticky",  1, 32'(tmo[1]), 1);

        // Backpressure: accept toggles, 5-word frame on requester 1
        k = 0; nacc = 0;
        for (int c = 0; c < 10; c++) begin
            oacc      = (c % 2) == 1;
            in1_valid = (k < 5);
            in1_data  = 32'hC0DE_0000 + 32'(k);
            in1_strb  = 4'(k + 1);
            in1_last  = (k == 4);
            #1;
            acc = a1[0] && in1_valid;
            tick();
            if (acc) begin k++; nacc++; end
        end
        chk("bp_accepts", 0, 32'(nacc), 5);
        chk("bp_fc1",     0, 32'(fc1[0]), 1);
        chk("bp_drain",   0, 32'(bsy[0]), 1);
        in1_valid = 0; in1_last = 0; oacc = 1;
        tick();
        chk("to_sticky_pre_rst", 1, 32'(tmo[1]), 1);

        // WAIT_IDLE=0: three single-word frames from requester 1
        rst = 1'b1; tick(); rst = 1'b0;
        chk("to_clr_by_rst", 1, 32'(tmo[1]), 0);
        in1_valid = 1; in1_last = 1; in1_data = 32'h0000_5EED;
        for (int j = 0; j < 6; j++) begin
            didle = 1'($urandom % 2);
            in1_strb = 4'($urandom);
            tick();
            if (j == 5) in1_valid = 0;
            if (j % 2 == 1) begin
                chk("nw_idle", 2, 32'(bsy[2]), 0);
                chk("nw_fc1",  2, 32'(fc1[2]), 32'((j + 1) / 2));
            end
        end
        chk("nw_fc1_total", 2, 32'(fc1[2]), 3);
        in1_last = 0;

        // Reset in the middle of a 4-word frame
        rst = 1'b1; tick(); rst = 1'b0;
        in0_valid = 1; in0_last = 0; oacc = 1; didle = 1;
        tick();
        for (int w = 0; w < 2; w++) begin
            in0_data = 32'hD000_0000 + 32'(w);
            tick();
        end
        in0_data = 32'hD000_0002;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("mr_busy", i, 32'(bsy[i]), 0);
            chk("mr_fc0",  i, 32'(fc0[i]), 0);
            chk("mr_fc1",  i, 32'(fc1[i]), 0);
            chk("mr_acc0", i, 32'(a0[i]),  0);
            chk("mr_acc1", i, 32'(a1[i]),  0);
        end
        in0_valid = 0;

        // Random traffic against the model
        for (int c = 0; c < 3000; c++) begin
            in0_valid = ($urandom % 4) != 0;
            in1_valid = ($urandom % 4) != 0;
            in0_data  = $urandom;
            in1_data  = $urandom;
            in0_strb  = 4'($urandom);
            in1_strb  = 4'($urandom);
            in0_last  = ($urandom % 4) == 0;
            in1_last  = ($urandom % 4) == 0;
            oacc      = ($urandom % 3) != 0;
            didle     = ($urandom % 3) != 0;
            rst       = ($urandom % 300) == 0;
            tick();
        end
        rst = 0;
        tick();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_jpeg_stream_arb
`default_nettype wire
